// File: rtl/arp_cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : arp_cache_ctrl
// Purpose  : Direct-mapped IP-to-MAC ARP cache controller. Serves lookup and
//            learn requests against a 1024-entry table. The table is indexed
//            by the 10-bit address returned combinationally from an external
//            hash stage. The whole table is cleared after every reset.
// Ports    : clk            - system clock, rising edge
//            reset          - asynchronous, active-low reset
//            lkp_req/lkp_ip - lookup request (level-held until lkp_ack)
//            lkp_ack        - one-cycle lookup-complete pulse
//            lkp_hit/lkp_mac- lookup result, held until the next lkp_ack
//            lrn_req/lrn_ip/lrn_mac - learn request (level-held until lrn_ack)
//            lrn_ack        - one-cycle write-complete pulse
//            hash_data/hash_dvald - IP presented to the hash stage
//            hash_addr      - table address returned by the hash stage
//            busy           - high in every state except IDLE
// Options  : ARP_AGE_EN     - when defined, entries carry a 2-bit age and a
//                             background sweep ages them out every
//                             AGE_PERIOD cycles per entry step.
// Revision : 1.0 - initial release
// ============================================================================
module arp_cache_ctrl
`ifdef ARP_AGE_EN
#(
    parameter int AGE_PERIOD = 1000000
)
`endif
(
    input  logic        clk,
    input  logic        reset,
    input  logic        lkp_req,
    input  logic [31:0] lkp_ip,
    output logic        lkp_ack,
    output logic        lkp_hit,
    output logic [47:0] lkp_mac,
    input  logic        lrn_req,
    input  logic [31:0] lrn_ip,
    input  logic [47:0] lrn_mac,
    output logic        lrn_ack,
    output logic [31:0] hash_data,
    output logic        hash_dvald,
    input  logic [9:0]  hash_addr,
    output logic        busy
);

    // Entry layout: {[age(2)], valid(1), ip(32), mac(48)}
    localparam int c_DEPTH   = 1024;
    localparam int c_IP_LSB  = 48;
    localparam int c_VLD_BIT = 80;
`ifdef ARP_AGE_EN
    localparam int c_AGE_LSB = 81;
    localparam int c_EW      = 83;
`else
    localparam int c_EW      = 81;
`endif

    typedef enum logic [2:0] {
        ST_CLEAR  = 3'd0,
        ST_IDLE   = 3'd1,
        ST_HASH   = 3'd2,
        ST_READ   = 3'd3,
        ST_CMP    = 3'd4,
        ST_WRITE  = 3'd5
`ifdef ARP_AGE_EN
        ,
        ST_SWP_RD = 3'd6,
        ST_SWP_WR = 3'd7
`endif
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic [c_EW-1:0]   r_mem [0:c_DEPTH-1];
    logic [c_EW-1:0]   r_rd_entry;

    logic              r_op_lrn;
    logic [31:0]       r_ip;
    logic [47:0]       r_mac;
    logic [9:0]        r_addr;
    logic [9:0]        r_clr_ptr;
    logic              r_clr_done;
    logic              r_lkp_hit;
    logic [47:0]       r_lkp_mac;

    logic              w_ram_we;
    logic [9:0]        w_ram_addr;
    logic [c_EW-1:0]   w_ram_wdata;
    logic              w_cmp_hit;
    logic [47:0]       w_cmp_mac;

`ifdef ARP_AGE_EN
    logic [31:0]       r_age_cnt;
    logic              r_swp_pend;
    logic [9:0]        r_swp_ptr;
    logic              w_age_expire;
    logic              w_swp_start;

    assign w_age_expire = (r_age_cnt == 32'(AGE_PERIOD - 1));
    assign w_swp_start  = (r_state == ST_IDLE) && r_swp_pend;
`endif

    // Table RAM: single port, synchronous read, no reset on the array.
    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            r_mem[w_ram_addr] <= w_ram_wdata;
        end
        r_rd_entry <= r_mem[w_ram_addr];
    end

    assign w_cmp_hit = r_rd_entry[c_VLD_BIT] && (r_rd_entry[c_IP_LSB +: 32] == r_ip);
    assign w_cmp_mac = w_cmp_hit ? r_rd_entry[47:0] : 48'd0;

    // The result is combinational during CMP so it lines up with lkp_ack,
    // and the registered copy holds it until the next lookup completes.
    assign lkp_hit = (r_state == ST_CMP) ? w_cmp_hit : r_lkp_hit;
    assign lkp_mac = (r_state == ST_CMP) ? w_cmp_mac : r_lkp_mac;
    assign busy    = (r_state != ST_IDLE);

    always_comb begin
        w_next      = r_state;
        w_ram_we    = 1'b0;
        w_ram_addr  = r_addr;
        w_ram_wdata = '0;
        lkp_ack     = 1'b0;
        lrn_ack     = 1'b0;
        hash_data   = 32'd0;
        hash_dvald  = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                w_ram_addr = r_clr_ptr;
                if (r_clr_done) begin
                    w_next = ST_IDLE;
                end else begin
                    w_ram_we = 1'b1;
                end
            end
            ST_IDLE: begin
`ifdef ARP_AGE_EN
                if (r_swp_pend) begin
                    w_next = ST_SWP_RD;
                end else
`endif
                if (lrn_req || lkp_req) begin
                    w_next = ST_HASH;
                end
            end
            ST_HASH: begin
                hash_data  = r_ip;
                hash_dvald = 1'b1;
                w_next     = r_op_lrn ? ST_WRITE : ST_READ;
            end
            ST_READ: begin
                w_next = ST_CMP;
            end
            ST_CMP: begin
                lkp_ack = 1'b1;
                w_next  = ST_IDLE;
            end
            ST_WRITE: begin
                w_ram_we = 1'b1;
`ifdef ARP_AGE_EN
                w_ram_wdata = {2'b11, 1'b1, r_ip, r_mac};
`else
                w_ram_wdata = {1'b1, r_ip, r_mac};
`endif
                lrn_ack = 1'b1;
                w_next  = ST_IDLE;
            end
`ifdef ARP_AGE_EN
            ST_SWP_RD: begin
                w_ram_addr = r_swp_ptr;
                w_next     = ST_SWP_WR;
            end
            ST_SWP_WR: begin
                w_ram_addr  = r_swp_ptr;
                w_ram_wdata = r_rd_entry;
                if (r_rd_entry[c_VLD_BIT]) begin
                    w_ram_we = 1'b1;
                    if (r_rd_entry[c_AGE_LSB +: 2] == 2'd0) begin
                        w_ram_wdata[c_VLD_BIT] = 1'b0;
                    end else begin
                        w_ram_wdata[c_AGE_LSB +: 2] = r_rd_entry[c_AGE_LSB +: 2] - 2'd1;
                    end
                end
                w_next = ST_IDLE;
            end
`endif
            default: begin
                w_next = ST_CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_CLEAR;
            r_clr_ptr  <= 10'd0;
            r_clr_done <= 1'b0;
            r_op_lrn   <= 1'b0;
            r_ip       <= 32'd0;
            r_mac      <= 48'd0;
            r_addr     <= 10'd0;
            r_lkp_hit  <= 1'b0;
            r_lkp_mac  <= 48'd0;
        end else begin
            r_state <= w_next;
            // The terminal flag gives one extra cycle after address 1023
            // before leaving CLEAR, so the pointer can simply wrap.
            if (r_state == ST_CLEAR && !r_clr_done) begin
                r_clr_ptr <= r_clr_ptr + 10'd1;
                if (r_clr_ptr == 10'd1023) begin
                    r_clr_done <= 1'b1;
                end
            end
            // Learn has priority; a concurrent lookup stays pending on its
            // level-held request.
            if (r_state == ST_IDLE && w_next == ST_HASH) begin
                if (lrn_req) begin
                    r_op_lrn <= 1'b1;
                    r_ip     <= lrn_ip;
                    r_mac    <= lrn_mac;
                end else begin
                    r_op_lrn <= 1'b0;
                    r_ip     <= lkp_ip;
                end
            end
            if (r_state == ST_HASH) begin
                r_addr <= hash_addr;
            end
            if (r_state == ST_CMP) begin
                r_lkp_hit <= w_cmp_hit;
                r_lkp_mac <= w_cmp_mac;
            end
        end
    end

`ifdef ARP_AGE_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_age_cnt  <= 32'd0;
            r_swp_pend <= 1'b0;
            r_swp_ptr  <= 10'd0;
        end else begin
            r_age_cnt  <= w_age_expire ? 32'd0 : r_age_cnt + 32'd1;
            r_swp_pend <= w_age_expire | (r_swp_pend & ~w_swp_start);
            if (r_state == ST_SWP_WR) begin
                r_swp_ptr <= r_swp_ptr + 10'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_arp_cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_arp_cache_ctrl
// Purpose  : Self-checking bench for arp_cache_ctrl (default build). Provides
//            a hash stage model, a directed vector table, hand-written
//            sequences for arbitration and mid-operation reset, and a random
//            phase checked against an array-based table model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_arp_cache_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        lkp_req = 1'b0;
    logic [31:0] lkp_ip = 32'd0;
    logic        lkp_ack;
    logic        lkp_hit;
    logic [47:0] lkp_mac;
    logic        lrn_req = 1'b0;
    logic [31:0] lrn_ip = 32'd0;
    logic [47:0] lrn_mac = 48'd0;
    logic        lrn_ack;
    logic [31:0] hash_data;
    logic        hash_dvald;
    logic [9:0]  hash_addr;
    logic        busy;

    arp_cache_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .lkp_req    (lkp_req),
        .lkp_ip     (lkp_ip),
        .lkp_ack    (lkp_ack),
        .lkp_hit    (lkp_hit),
        .lkp_mac    (lkp_mac),
        .lrn_req    (lrn_req),
        .lrn_ip     (lrn_ip),
        .lrn_mac    (lrn_mac),
        .lrn_ack    (lrn_ack),
        .hash_data  (hash_data),
        .hash_dvald (hash_dvald),
        .hash_addr  (hash_addr),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Hash stage model; bits 31:26 do not contribute, which makes collisions
    // easy to construct by flipping them.
    function automatic logic [9:0] hfn(input logic [31:0] ip);
        return ip[9:0] ^ ip[25:16];
    endfunction
    assign hash_addr = hfn(hash_data);

    int n_checks = 0;
    int n_fail   = 0;

    // Reference table model
    bit          m_valid [1024];
    logic [31:0] m_ip    [1024];
    logic [47:0] m_mac   [1024];

    task automatic model_clear();
        for (int i = 0; i < 1024; i++) begin
            m_valid[i] = 1'b0;
            m_ip[i]    = 32'd0;
            m_mac[i]   = 48'd0;
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Learn request; returns cycles from acceptance edge to visible ack.
    task automatic do_learn(input logic [31:0] ip, input logic [47:0] mac, output int lat);
        @(negedge clk);
        lrn_req = 1'b1;
        lrn_ip  = ip;
        lrn_mac = mac;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!lrn_ack && lat < 40);
        @(posedge clk);
        #1 lrn_req = 1'b0;
        m_valid[hfn(ip)] = 1'b1;
        m_ip[hfn(ip)]    = ip;
        m_mac[hfn(ip)]   = mac;
    endtask

    // Lookup request; also checks the hash interface in the HASH cycle and
    // that the result holds once the ack has gone.
    task automatic do_lookup(input logic [31:0] ip, output int lat,
                             output logic hit, output logic [47:0] mac);
        @(negedge clk);
        lkp_req = 1'b1;
        lkp_ip  = ip;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                check("hash_dvald_in_hash", {63'd0, hash_dvald}, 64'd1);
                check("hash_data_in_hash", {32'd0, hash_data}, {32'd0, ip});
            end
        end while (!lkp_ack && lat < 40);
        hit = lkp_hit;
        mac = lkp_mac;
        @(posedge clk);
        #1 lkp_req = 1'b0;
        @(negedge clk);
        check("lkp_ack_pulse_end", {63'd0, lkp_ack}, 64'd0);
        check("hash_dvald_idle", {63'd0, hash_dvald}, 64'd0);
        check("lkp_hit_held", {63'd0, lkp_hit}, {63'd0, hit});
        check("lkp_mac_held", {16'd0, lkp_mac}, {16'd0, mac});
    endtask

    // Counts rising edges after reset release until busy falls.
    task automatic measure_clear(output int edges);
        edges = 0;
        do begin
            @(posedge clk);
            #1 edges++;
        end while (busy && edges < 3000);
    endtask

    task automatic expect_lookup(input string name, input logic [31:0] ip);
        int          lat;
        logic        hit;
        logic [47:0] mac;
        logic        e_hit;
        logic [47:0] e_mac;
        e_hit = m_valid[hfn(ip)] && (m_ip[hfn(ip)] == ip);
        e_mac = e_hit ? m_mac[hfn(ip)] : 48'd0;
        do_lookup(ip, lat, hit, mac);
        check({name, "_lat"}, 64'(lat), 64'd3);
        check({name, "_hit"}, {63'd0, hit}, {63'd0, e_hit});
        check({name, "_mac"}, {16'd0, mac}, {16'd0, e_mac});
    endtask

    typedef struct {
        bit          is_lrn;
        logic [31:0] ip;
        logic [47:0] mac;
        bit          exp_hit;
        logic [47:0] exp_mac;
    } vec_t;

    localparam logic [31:0] c_IP_A = 32'h0B0C0D0E;
    localparam logic [31:0] c_IP_B = 32'hF70C0D0E;  // same hash as c_IP_A

    vec_t vecs [10];

    initial begin
        int          lat;
        int          lat_l;
        int          lat_k;
        int          edges;
        int          acks_seen;
        logic        hit;
        logic [47:0] mac;
        logic [31:0] pool [8];

        vecs[0] = '{1'b0, 32'h0A000001, 48'd0,              1'b0, 48'd0};
        vecs[1] = '{1'b1, 32'hC0A80001, 48'h001122334455,   1'b0, 48'd0};
        vecs[2] = '{1'b0, 32'hC0A80001, 48'd0,              1'b1, 48'h001122334455};
        vecs[3] = '{1'b1, c_IP_A,       48'hAAAAAAAAAAAA,   1'b0, 48'd0};
        vecs[4] = '{1'b1, c_IP_B,       48'hBBBBBBBBBBBB,   1'b0, 48'd0};
        vecs[5] = '{1'b0, c_IP_A,       48'd0,              1'b0, 48'd0};
        vecs[6] = '{1'b0, c_IP_B,       48'd0,              1'b1, 48'hBBBBBBBBBBBB};
        vecs[7] = '{1'b0, 32'hC0A80001, 48'd0,              1'b1, 48'h001122334455};
        vecs[8] = '{1'b1, 32'hC0A80001, 48'h665544332211,   1'b0, 48'd0};
        vecs[9] = '{1'b0, 32'hC0A80001, 48'd0,              1'b1, 48'h665544332211};

        model_clear();

        // Reset values
        #12;
        check("rst_busy", {63'd0, busy}, 64'd1);
        check("rst_lkp_ack", {63'd0, lkp_ack}, 64'd0);
        check("rst_lrn_ack", {63'd0, lrn_ack}, 64'd0);
        check("rst_lkp_hit", {63'd0, lkp_hit}, 64'd0);
        check("rst_lkp_mac", {16'd0, lkp_mac}, 64'd0);
        check("rst_hash_dvald", {63'd0, hash_dvald}, 64'd0);
        check("rst_hash_data", {32'd0, hash_data}, 64'd0);

        // Clear duration: busy falls on the 1025th edge after release
        @(negedge clk);
        reset = 1'b1;
        measure_clear(edges);
        check("clear_edges", 64'(edges), 64'd1025);

        // Directed vector table
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].is_lrn) begin
                do_learn(vecs[i].ip, vecs[i].mac, lat);
                check($sformatf("vec%0d_lrn_lat", i), 64'(lat), 64'd2);
            end else begin
                do_lookup(vecs[i].ip, lat, hit, mac);
                check($sformatf("vec%0d_lkp_lat", i), 64'(lat), 64'd3);
                check($sformatf("vec%0d_hit", i), {63'd0, hit}, {63'd0, vecs[i].exp_hit});
                check($sformatf("vec%0d_mac", i), {16'd0, mac}, {16'd0, vecs[i].exp_mac});
            end
        end

        // Learn and lookup raised together: learn acks at 2, lookup at 6
        @(negedge clk);
        lrn_req = 1'b1;
        lrn_ip  = 32'h0A0B0C0D;
        lrn_mac = 48'h0C0FFEE0BEEF;
        lkp_req = 1'b1;
        lkp_ip  = 32'h0A0B0C0D;
        lat_l = 0;
        lat_k = 0;
        hit = 1'b0;
        mac = 48'd0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (lrn_ack && lat_l == 0) lat_l = c;
            if (lkp_ack && lat_k == 0) begin
                lat_k = c;
                hit = lkp_hit;
                mac = lkp_mac;
            end
            @(posedge clk);
            #1;
            if (lat_l != 0) lrn_req = 1'b0;
            if (lat_k != 0) lkp_req = 1'b0;
        end
        lrn_req = 1'b0;
        lkp_req = 1'b0;
        m_valid[hfn(32'h0A0B0C0D)] = 1'b1;
        m_ip[hfn(32'h0A0B0C0D)]    = 32'h0A0B0C0D;
        m_mac[hfn(32'h0A0B0C0D)]   = 48'h0C0FFEE0BEEF;
        check("both_lrn_lat", 64'(lat_l), 64'd2);
        check("both_lkp_lat", 64'(lat_k), 64'd6);
        check("both_lkp_hit", {63'd0, hit}, 64'd1);
        check("both_lkp_mac", {16'd0, mac}, 64'h0C0FFEE0BEEF);

        // Reset asserted in the READ cycle of a lookup
        @(negedge clk);
        lkp_req = 1'b1;
        lkp_ip  = 32'hC0A80001;
        @(negedge clk);  // HASH
        @(negedge clk);  // READ
        reset = 1'b0;
        #1;
        check("abort_busy", {63'd0, busy}, 64'd1);
        check("abort_lkp_hit", {63'd0, lkp_hit}, 64'd0);
        check("abort_lkp_mac", {16'd0, lkp_mac}, 64'd0);
        acks_seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (lkp_ack) acks_seen++;
        end
        lkp_req = 1'b0;
        check("abort_no_ack", 64'(acks_seen), 64'd0);
        reset = 1'b1;
        measure_clear(edges);
        check("reclear_edges", 64'(edges), 64'd1025);
        model_clear();
        expect_lookup("after_reset_miss", 32'hC0A80001);

        // Random phase against the table model
        pool[0] = 32'hC0A80001;
        pool[1] = 32'hC0A80002;
        pool[2] = 32'h0A000001;
        pool[3] = c_IP_A;
        pool[4] = c_IP_B;
        pool[5] = 32'h12345678;
        pool[6] = 32'h12345678 ^ 32'hFC000000;
        pool[7] = 32'hDEADBEEF;
        for (int n = 0; n < 80; n++) begin
            logic [31:0] rip;
            logic [47:0] rmac;
            rip  = pool[$urandom_range(0, 7)];
            rmac = {16'($urandom()), 32'($urandom())};
            if ($urandom_range(0, 99) < 40) begin
                do_learn(rip, rmac, lat);
                check("rnd_lrn_lat", 64'(lat), 64'd2);
            end else begin
                expect_lookup("rnd_lkp", rip);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
